// File: rtl/sign_ext.sv
// Immediate / load-data sign and zero extender with a registered copy of the result.
// Optional build macro SIGNEXT_ILLEGAL_OP_EN adds illegal_op and a sticky illegal_op_seen_q flag.
module sign_ext #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] unextended_data,
   input  logic [2:0]            sx_op,
`ifdef SIGNEXT_ILLEGAL_OP_EN
   output logic                  illegal_op,
   output logic                  illegal_op_seen_q,
`endif
   output logic [DATA_WIDTH-1:0] sign_extended_data,
   output logic [DATA_WIDTH-1:0] sign_extended_data_q
);

   // Encodings mirror the isa_shared package.
   localparam logic [2:0] SX_1100  = 3'd0;
   localparam logic [2:0] SX_3100  = 3'd1;
   localparam logic [2:0] SX_1500  = 3'd2;
   localparam logic [2:0] SX_0700  = 3'd3;
   localparam logic [2:0] SX_2000  = 3'd4;
   localparam logic [2:0] SXU_0700 = 3'd5;
   localparam logic [2:0] SXU_1500 = 3'd6;

   logic [DATA_WIDTH-1:0] ext_d;
   logic [DATA_WIDTH-1:0] ext_q;

   // A size cast of a signed field replicates its top bit into the widened result.
   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                    input logic [2:0]            op);
      logic signed [11:0] f12;
      logic signed [31:0] f32;
      logic signed [15:0] f16;
      logic signed [7:0]  f8;
      logic signed [20:0] f21;
      logic        [7:0]  u8;
      logic        [15:0] u16;
      f12 = raw[11:0];
      f32 = raw[31:0];
      f16 = raw[15:0];
      f8  = raw[7:0];
      f21 = raw[20:0];
      u8  = raw[7:0];
      u16 = raw[15:0];
      case (op)
         SX_1100:  extend = DATA_WIDTH'(f12);
         SX_3100:  extend = DATA_WIDTH'(f32);
         SX_1500:  extend = DATA_WIDTH'(f16);
         SX_0700:  extend = DATA_WIDTH'(f8);
         SX_2000:  extend = DATA_WIDTH'(f21);
         SXU_0700: extend = DATA_WIDTH'(u8);
         SXU_1500: extend = DATA_WIDTH'(u16);
         default:  extend = '0;
      endcase
   endfunction

   always_comb begin
      ext_d = extend(unextended_data, sx_op);
   end

   assign sign_extended_data   = ext_d;
   assign sign_extended_data_q = ext_q;

   // Registered stage: reloaded every edge, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q <= '0;
      end else begin
         ext_q <= ext_d;
      end
   end

`ifdef SIGNEXT_ILLEGAL_OP_EN
   logic illegal_op_seen_d;

   always_comb begin
      illegal_op        = (sx_op == 3'd7);
      illegal_op_seen_d = illegal_op_seen_q | illegal_op;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_op_seen_q <= 1'b0;
      end else begin
         illegal_op_seen_q <= illegal_op_seen_d;
      end
   end
`endif

endmodule

// File: tb/tb_sign_ext.sv
// Scoreboard bench for sign_ext: stimulus queues expected values, a monitor samples and compares.
`timescale 1ns/1ps
module tb_sign_ext;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [DW-1:0] unextended_data;
   logic [2:0]    sx_op;
   logic [DW-1:0] sign_extended_data;
   logic [DW-1:0] sign_extended_data_q;
`ifdef SIGNEXT_ILLEGAL_OP_EN
   logic          illegal_op;
   logic          illegal_op_seen_q;
`endif

   sign_ext #(.DATA_WIDTH(DW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .unextended_data      (unextended_data),
      .sx_op                (sx_op),
`ifdef SIGNEXT_ILLEGAL_OP_EN
      .illegal_op           (illegal_op),
      .illegal_op_seen_q    (illegal_op_seen_q),
`endif
      .sign_extended_data   (sign_extended_data),
      .sign_extended_data_q (sign_extended_data_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 comb data, 1 registered data, 2 illegal_op, 3 illegal_op_seen_q
   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t  sb_q[$];
   event  sample_ev;
   int    checks = 0;
   int    errors = 0;

   task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
      exp_t e;
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   // Monitor: sample 1ns after each request, away from clock edges.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(sample_ev);
         #1;
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
               0:       act = sign_extended_data;
               1:       act = sign_extended_data_q;
`ifdef SIGNEXT_ILLEGAL_OP_EN
               2:       act = {31'd0, illegal_op};
               3:       act = {31'd0, illegal_op_seen_q};
`endif
               default: act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   // Independent reference: mask the field, then OR in the upper ones when the field is negative.
   function automatic logic [31:0] ref_ext(input logic [31:0] in, input logic [2:0] op);
      int          k;
      bit          sgn;
      logic [31:0] mask;
      case (op)
         3'd0: begin k = 12; sgn = 1; end
         3'd1: begin k = 32; sgn = 1; end
         3'd2: begin k = 16; sgn = 1; end
         3'd3: begin k = 8;  sgn = 1; end
         3'd4: begin k = 21; sgn = 1; end
         3'd5: begin k = 8;  sgn = 0; end
         3'd6: begin k = 16; sgn = 0; end
         default: return 32'd0;
      endcase
      mask = (k == 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
      ref_ext = in & mask;
      if (sgn && in[k-1]) ref_ext = ref_ext | ~mask;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] in);
      sx_op           = op;
      unextended_data = in;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rv;
      // Reset state before any clock edge
      rst = 1'b1;
      drive(3'd3, 32'h0000_0080);
      expect_val(1, 32'h0, "q_reset_before_edge");
      @(posedge clk);
      #1;
      expect_val(1, 32'h0, "q_held_in_reset");

      // Directed combinational vectors
      drive(3'd0, 32'hFFFF_F800); expect_val(0, 32'hFFFF_F800, "sx1100_neg");
      drive(3'd0, 32'h1234_57FF); expect_val(0, 32'h0000_07FF, "sx1100_pos");
      drive(3'd1, 32'h8000_0001); expect_val(0, 32'h8000_0001, "sx3100");
      drive(3'd4, 32'h0010_0000); expect_val(0, 32'hFFF0_0000, "sx2000_neg");
      drive(3'd4, 32'hFFEF_FFFF); expect_val(0, 32'h000F_FFFF, "sx2000_pos");
      drive(3'd3, 32'hABCD_EF80); expect_val(0, 32'hFFFF_FF80, "sx0700");
      drive(3'd2, 32'h0000_8001); expect_val(0, 32'hFFFF_8001, "sx1500");
      drive(3'd5, 32'hFFFF_FF80); expect_val(0, 32'h0000_0080, "sxu0700");
      drive(3'd6, 32'hFFFF_8001); expect_val(0, 32'h0000_8001, "sxu1500");
      drive(3'd7, 32'hFFFF_FFFF); expect_val(0, 32'h0000_0000, "reserved_zero");

      // Random vectors per op against the reference
      for (int op = 0; op < 8; op++) begin
         for (int n = 0; n < 10; n++) begin
            rv = $random;
            drive(op[2:0], rv);
            expect_val(0, ref_ext(rv, op[2:0]), $sformatf("rand_op%0d_%h", op, rv));
         end
      end

      // Registered path: first load after reset release
      @(negedge clk);
      drive(3'd3, 32'h0000_0080);
      rst = 1'b0;
      expect_val(1, 32'h0, "q_before_first_edge");
      @(posedge clk);
      expect_val(1, 32'hFFFF_FF80, "q_first_load");
      @(negedge clk);
      drive(3'd6, 32'h0000_9000);
      @(posedge clk);
      expect_val(1, 32'h0000_9000, "q_second_load");

      // Async reset between edges
      @(negedge clk);
      rst = 1'b1;
      expect_val(1, 32'h0, "q_async_clear");
      expect_val(0, 32'h0000_9000, "comb_during_rst");
      @(negedge clk);
      rst = 1'b0;

`ifdef SIGNEXT_ILLEGAL_OP_EN
      expect_val(3, 32'd0, "seen_initial");
      drive(3'd7, 32'hFFFF_FFFF);
      expect_val(2, 32'd1, "illegal_op_high");
      expect_val(0, 32'd0, "illegal_data_zero");
      @(posedge clk);
      expect_val(3, 32'd1, "seen_set");
      @(negedge clk);
      drive(3'd0, 32'h0);
      expect_val(2, 32'd0, "illegal_op_low");
      @(posedge clk);
      @(posedge clk);
      expect_val(3, 32'd1, "seen_sticky");
      @(negedge clk);
      rst = 1'b1;
      expect_val(3, 32'd0, "seen_cleared_by_rst");
      @(negedge clk);
      rst = 1'b0;
`endif

      #5;
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
